alu_ctrl_unit: RTL and testbench
================================

Name: alu_ctrl_unit

Overview:
- ALU control decoder for the pipelined MIPS datapath, between the main control unit and the EX-stage ALU.
- Maps the 3-bit ALUOp from main control, plus the 6-bit R-type funct field, to the 3-bit ALU operation select ALUCtr.
- Output is registered: one clock of latency, so it lines up with the ID/EX pipeline boundary.
- Also flags unsupported R-type funct codes.

Parameters:
- none (all encodings are fixed constants in the shared package)

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high; forces outputs to their reset values immediately
- en  input  1  capture enable; 0 holds outputs (pipeline stall)
- ALUOp  input  3  operation class from main control
- func  input  6  instruction funct field, bits [5:0]; used only when ALUOp=3'b111
- ALUCtr  output  3  registered ALU operation select
- illegal  output  1  registered; 1 when an R-type funct is unsupported

Behaviour:
- ALUCtr encoding:
  - 000 AND, 001 OR, 010 ADD, 011 SLL
  - 100 XOR, 101 SLTU, 110 SUB, 111 SLT
- ALUOp decode (illegal=0 for every non-R class):
  - 000 -> ADD (lw/sw/addi/addiu)
  - 001 -> SUB (beq/bne)
  - 010 -> AND (andi)
  - 011 -> OR (ori)
  - 100 -> SLT (slti)
  - 101 -> SLTU (sltiu)
  - 110 -> XOR (xori)
  - 111 -> R-type: decode func
- R-type func decode:
  - 0x00 -> SLL
  - 0x20, 0x21 -> ADD
  - 0x22, 0x23 -> SUB
  - 0x24 -> AND
  - 0x25 -> OR
  - 0x26 -> XOR
  - 0x2A -> SLT
  - 0x2B -> SLTU
  - all other 54 codes -> ALUCtr=ADD, illegal=1
- func is ignored when ALUOp != 111. A func change alone never alters outputs in that case.
- Next-state logic is purely combinational from (ALUOp, func). There is no other internal state.
- Latency: inputs sampled at rising clk with en=1 appear on ALUCtr/illegal after that edge, one cycle.
- en=0 at an edge: outputs hold their previous values.
- reset=1: ALUCtr=3'b010 (ADD) and illegal=0 at once, regardless of clk or en.
- Reset mid-operation: the pending capture is discarded.
- Release of reset: the first capture happens on the first rising edge with reset=0 and en=1.
- Reset has priority over en.
- X/Z on ALUOp is not required to be handled; the default branch of the ALUOp decode yields ADD with illegal=0.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - ALUOp class constants (ALUOP_ADD..ALUOP_RTYPE)
  - ALUCtr operation constants (ALU_AND..ALU_SLT)
  - funct code constants (FN_SLL, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_SLT, FN_SLTU)
- One combinational sub-module, alu_funct_decode: func -> (op, illegal).
- The top level holds the ALUOp mux plus the output register with async reset and enable.

Test Plan:
- Reset: assert reset mid-cycle with ALUOp=111, func=0x22 previously captured -> ALUCtr=010 and illegal=0 immediately, before the next clk edge.
- ALUOp sweep: en=1, func=0x3F, step ALUOp 000..110, one per cycle -> ALUCtr = 010, 110, 000, 001, 111, 101, 100 one cycle later; illegal=0 throughout (proves func is ignored).
- R-type legal: ALUOp=111 with func 0x00, 0x20, 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x2A, 0x2B -> ALUCtr 011, 010, 010, 110, 110, 000, 001, 100, 111, 101 respectively; illegal=0.
- R-type full sweep: ALUOp=111, func 0..63 one per cycle -> the 54 codes outside the legal list give ALUCtr=010 and illegal=1.
- Stall: capture ALUOp=001, then set en=0 and ALUOp=011 for 3 cycles -> ALUCtr stays 110; restore en=1 -> ALUCtr=001 after the next edge.
- Latency check: change ALUOp 000->001 just after an edge -> ALUCtr remains 010 until the following rising edge, then becomes 110.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control path: ALUOp classes, ALUCtr operation
// selects and the R-type funct codes the decoder recognises.
package alu_ctrl_pkg;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_AND   = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_SLT   = 3'b100;
    localparam logic [2:0] ALUOP_SLTU  = 3'b101;
    localparam logic [2:0] ALUOP_XOR   = 3'b110;
    localparam logic [2:0] ALUOP_RTYPE = 3'b111;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SLL  = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [2:0] op;
        logic       illegal;
    } alu_dec_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational R-type funct decoder: maps the funct field to an ALU select
// and flags codes the datapath does not implement.
module alu_funct_decode
    import alu_ctrl_pkg::*;
(
    input  logic [5:0] func,
    output logic [2:0] op,
    output logic       illegal
);

    always_comb begin
        op      = ALU_ADD;
        illegal = 1'b0;
        case (func)
            FN_SLL:           op = ALU_SLL;
            FN_ADD, FN_ADDU:  op = ALU_ADD;
            FN_SUB, FN_SUBU:  op = ALU_SUB;
            FN_AND:           op = ALU_AND;
            FN_OR:            op = ALU_OR;
            FN_XOR:           op = ALU_XOR;
            FN_SLT:           op = ALU_SLT;
            FN_SLTU:          op = ALU_SLTU;
            // Unsupported codes still drive a harmless ADD so the EX stage stays defined.
            default: begin
                op      = ALU_ADD;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_unit.sv
// ALU control decoder: selects the ALU operation from ALUOp (and funct for
// R-type) and registers it at the ID/EX boundary with stall support.
module alu_ctrl_unit
    import alu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] ALUOp,
    input  logic [5:0] func,
    output logic [2:0] ALUCtr,
    output logic       illegal
);

    logic [2:0] fn_op;
    logic       fn_illegal;
    alu_dec_t   dec_p0;
    alu_dec_t   dec_p1;

    alu_funct_decode u_funct_decode (
        .func    (func),
        .op      (fn_op),
        .illegal (fn_illegal)
    );

    always_comb begin
        dec_p0.op      = ALU_ADD;
        dec_p0.illegal = 1'b0;
        case (ALUOp)
            ALUOP_ADD:   dec_p0.op = ALU_ADD;
            ALUOP_SUB:   dec_p0.op = ALU_SUB;
            ALUOP_AND:   dec_p0.op = ALU_AND;
            ALUOP_OR:    dec_p0.op = ALU_OR;
            ALUOP_SLT:   dec_p0.op = ALU_SLT;
            ALUOP_SLTU:  dec_p0.op = ALU_SLTU;
            ALUOP_XOR:   dec_p0.op = ALU_XOR;
            ALUOP_RTYPE: begin
                dec_p0.op      = fn_op;
                dec_p0.illegal = fn_illegal;
            end
            default: begin
                dec_p0.op      = ALU_ADD;
                dec_p0.illegal = 1'b0;
            end
        endcase
    end

    // p0 -> p1: ID/EX register; en=0 holds the previous decode during a stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_p1.op      <= ALU_ADD;
            dec_p1.illegal <= 1'b0;
        end else if (en) begin
            dec_p1 <= dec_p0;
        end
    end

    assign ALUCtr  = dec_p1.op;
    assign illegal = dec_p1.illegal;

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Scoreboard bench for alu_ctrl_unit: expected {ALUCtr,illegal} pushed when
// stimulus is applied, popped and compared one clock later.
module tb_alu_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] ALUOp;
    logic [5:0] func;
    logic [2:0] ALUCtr;
    logic       illegal;

    int tests = 0;
    int fails = 0;
    logic [3:0] sb[$];
    logic [3:0] held;

    alu_ctrl_unit dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .ALUOp   (ALUOp),
        .func    (func),
        .ALUCtr  (ALUCtr),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got ALUCtr=%b illegal=%b expected ALUCtr=%b illegal=%b",
                     tag, got[3:1], got[0], exp[3:1], exp[0]);
        end
    endtask

    function automatic logic [3:0] model(input logic [2:0] op, input logic [5:0] fn);
        logic [2:0] cls [8];
        cls = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b101, 3'b100, 3'b010};
        if (op != 3'b111) return {cls[op], 1'b0};
        case (fn)
            6'd0:  return 4'b0110;
            6'd32: return 4'b0100;
            6'd33: return 4'b0100;
            6'd34: return 4'b1100;
            6'd35: return 4'b1100;
            6'd36: return 4'b0000;
            6'd37: return 4'b0010;
            6'd38: return 4'b1000;
            6'd42: return 4'b1110;
            6'd43: return 4'b1010;
            default: return 4'b0101;
        endcase
    endfunction

    // Entered and left at posedge+1.
    task automatic cycle(input string tag, input logic [2:0] op, input logic [5:0] fn, input logic e);
        logic [3:0] exp;
        ALUOp = op;
        func  = fn;
        en    = e;
        #1;
        check({tag, "_pre_edge"}, {ALUCtr, illegal}, held);
        if (e) held = model(op, fn);
        sb.push_back(held);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, {ALUCtr, illegal}, 4'bxxxx);
        end else begin
            exp = sb.pop_front();
            check(tag, {ALUCtr, illegal}, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        ALUOp = 3'b111;
        func  = 6'h22;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {ALUCtr, illegal}, 4'b0100);
        reset = 1'b0;
        held  = 4'b0100;

        // ALUOp sweep with a funct that would be illegal if it were used
        for (int i = 0; i < 7; i++)
            cycle("aluop_sweep", 3'(i), 6'h3F, 1'b1);

        // func changes alone must not move a non-R result
        cycle("func_ignored_a", 3'b100, 6'h00, 1'b1);
        cycle("func_ignored_b", 3'b100, 6'h2B, 1'b1);

        // Full R-type funct sweep (covers legal and illegal codes)
        for (int f = 0; f < 64; f++)
            cycle("rtype_sweep", 3'b111, 6'(f), 1'b1);

        // Stall
        cycle("stall_capture", 3'b001, 6'h00, 1'b1);
        for (int k = 0; k < 3; k++)
            cycle("stall_hold", 3'b011, 6'h00, 1'b0);
        cycle("stall_release", 3'b011, 6'h00, 1'b1);

        // Latency 000 -> 001
        cycle("latency_add", 3'b000, 6'h00, 1'b1);
        cycle("latency_sub", 3'b001, 6'h00, 1'b1);

        // Asynchronous reset mid-cycle with a legal SUB captured
        cycle("pre_reset_sub", 3'b111, 6'h22, 1'b1);
        #3;
        ALUOp = 3'b001;
        en    = 1'b1;
        reset = 1'b1;
        #1;
        check("reset_async", {ALUCtr, illegal}, 4'b0100);
        @(posedge clk);
        #1;
        check("reset_over_en", {ALUCtr, illegal}, 4'b0100);
        reset = 1'b0;
        held  = 4'b0100;
        cycle("post_reset_hold", 3'b001, 6'h00, 1'b0);
        cycle("post_reset_first", 3'b111, 6'h2A, 1'b1);
        cycle("illegal_then_legal_a", 3'b111, 6'h3F, 1'b1);
        cycle("illegal_then_legal_b", 3'b010, 6'h3F, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
